// File: rtl/tt_check_pkg.sv
// Shared types and helpers for the truth-table checker.
package tt_check_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tt_state_t;

  localparam int MAX_N_IN = 8;

  function automatic int tt_vectors(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Down-counter giving SETTLE cycles of drive time per vector; expired marks the last one.
module tt_settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(SETTLE - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all input vectors of an external combinational circuit and compares
// its output against a latched minterm mask.
module truth_table_checker
  import tt_check_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [(1<<N_IN)-1:0]  expected,
  output logic [N_IN-1:0]       dut_in,
  input  logic                  dut_f,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_IN:0]         err_count,
  output logic [N_IN-1:0]       first_err,
  output logic [N_IN:0]         ones_count
);

  localparam int NV = tt_vectors(N_IN);

  tt_state_t          state_q, state_d;
  logic [NV-1:0]      shadow_q, shadow_d;
  logic [N_IN-1:0]    idx_q, idx_d;
  logic [N_IN:0]      err_q, err_d;
  logic [N_IN:0]      ones_q, ones_d;
  logic [N_IN-1:0]    first_q, first_d;
  logic               pass_q, pass_d;
  logic               timer_load;
  logic               timer_expired;
  logic               mismatch;
  logic               ones_hit;

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (timer_load),
    .en      (state_q == ST_DRIVE),
    .expired (timer_expired)
  );

  // Case-inequality so an unknown circuit output is scored as a mismatch
  // and never as a one.
  assign mismatch = (dut_f !== shadow_q[idx_q]);
  assign ones_hit = (dut_f === 1'b1);

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    err_d      = err_q;
    ones_d     = ones_q;
    first_d    = first_q;
    pass_d     = pass_q;
    timer_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shadow_d   = expected;
          err_d      = '0;
          ones_d     = '0;
          first_d    = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          timer_load = 1'b1;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (timer_expired) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (err_q == '0) begin
            first_d = idx_q;
          end
        end
        if (ones_hit) begin
          ones_d = ones_q + 1'b1;
        end
        if (&idx_q) begin
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          idx_d      = idx_q + 1'b1;
          timer_load = 1'b1;
          state_d    = ST_DRIVE;
        end
      end
      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      err_q    <= '0;
      ones_q   <= '0;
      first_q  <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      ones_q   <= ones_d;
      first_q  <= first_d;
      pass_q   <= pass_d;
    end
  end

  assign dut_in     = idx_q;
  assign busy       = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
  assign done       = (state_q == ST_DONE);
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_err  = first_q;
  assign ones_count = ones_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: table vectors, random masks vs a reference model,
// and hand sequences for mid-sweep start/reset and a slow-settle XOR instance.
module tb_truth_table_checker;

  logic        clk = 1'b0;
  logic        reset;

  logic        start_a;
  logic [15:0] exp_a;
  logic [15:0] circ_a;
  logic [3:0]  din_a;
  logic        f_a;
  logic        busy_a, done_a, pass_a;
  logic [4:0]  err_a, ones_a;
  logic [3:0]  first_a;

  logic        start_b;
  logic [3:0]  exp_b;
  logic [1:0]  din_b;
  logic        f_b;
  logic        busy_b, done_b, pass_b;
  logic [2:0]  err_b, ones_b;
  logic [1:0]  first_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign f_a = circ_a[din_a];
  assign f_b = din_b[1] ^ din_b[0];

  truth_table_checker #(.N_IN(4), .SETTLE(1)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .expected(exp_a),
    .dut_in(din_a), .dut_f(f_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_err(first_a), .ones_count(ones_a)
  );

  truth_table_checker #(.N_IN(2), .SETTLE(3)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .expected(exp_b),
    .dut_in(din_b), .dut_f(f_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_err(first_b), .ones_count(ones_b)
  );

  typedef struct {
    logic [15:0] circ;
    logic [15:0] expm;
    int          err;
    int          first;
    int          ones;
    int          pass;
  } vec_t;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Reference: compare every vector of the truth table against the mask.
  task automatic model(input logic [15:0] circ, input logic [15:0] expm,
                       output int err, output int first, output int ones, output int pass);
    err = 0; first = 0; ones = 0;
    for (int i = 0; i < 16; i++) begin
      if (circ[i]) ones++;
      if (circ[i] != expm[i]) begin
        if (err == 0) first = i;
        err++;
      end
    end
    pass = (err == 0) ? 1 : 0;
  endtask

  task automatic run_a(input string tag, input logic [15:0] circ, input logic [15:0] expm,
                       input int err_e, input int first_e, input int ones_e, input int pass_e,
                       input bit disturb);
    int n;
    int din_bad;
    int extra_done;
    circ_a  = circ;
    exp_a   = expm;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk({tag, ".busy_after_start"}, int'(busy_a), 1);
    n = 1; din_bad = 0;
    while (n < 200) begin
      if (done_a) break;
      if (int'(din_a) != (n - 1) / 2) din_bad++;
      if (disturb && n == 13) begin
        start_a = 1'b1;
        exp_a   = 16'h0000;
      end else begin
        start_a = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    // A start held in the DONE cycle must also be ignored.
    start_a = disturb;
    chk({tag, ".latency"}, n, 33);
    chk({tag, ".busy_at_done"}, int'(busy_a), 0);
    chk({tag, ".din_sequence_errs"}, din_bad, 0);
    chk({tag, ".err_count"}, int'(err_a), err_e);
    chk({tag, ".first_err"}, int'(first_a), first_e);
    chk({tag, ".ones_count"}, int'(ones_a), ones_e);
    chk({tag, ".pass"}, int'(pass_a), pass_e);
    extra_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
      if (done_a || busy_a) extra_done++;
    end
    chk({tag, ".no_extra_done_or_busy"}, extra_done, 0);
  endtask

  vec_t tbl[5];

  initial begin
    int e, f, o, p;
    int n;
    int din_bad;
    logic [15:0] rc, rm;

    tbl[0] = '{16'h2B15, 16'h2B15, 0, 0, 7, 1};
    tbl[1] = '{16'h2B15, 16'h2B14, 1, 0, 7, 0};
    tbl[2] = '{16'h0000, 16'h2B15, 7, 0, 0, 0};
    tbl[3] = '{16'hFFFF, 16'h0000, 16, 0, 16, 0};
    tbl[4] = '{16'h8000, 16'h0000, 1, 15, 1, 0};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    exp_a = 16'h0; circ_a = 16'h0; exp_b = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst.dut_in", int'(din_a), 0);
    chk("rst.busy", int'(busy_a), 0);
    chk("rst.done", int'(done_a), 0);
    chk("rst.pass", int'(pass_a), 0);
    chk("rst.err", int'(err_a), 0);
    chk("rst.first", int'(first_a), 0);
    chk("rst.ones", int'(ones_a), 0);

    for (int i = 0; i < 5; i++) begin
      run_a($sformatf("tbl%0d", i), tbl[i].circ, tbl[i].expm,
            tbl[i].err, tbl[i].first, tbl[i].ones, tbl[i].pass, 1'b0);
    end

    for (int i = 0; i < 6; i++) begin
      rc = 16'($urandom);
      rm = rc ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
      if (i == 0) rm = rc;
      model(rc, rm, e, f, o, p);
      run_a($sformatf("rnd%0d", i), rc, rm, e, f, o, p, 1'b0);
    end

    // Mid-sweep start and mask change at vector 6 are both ignored.
    run_a("disturb", 16'h2B15, 16'h2B15, 0, 0, 7, 1, 1'b1);

    // Reset at vector 5 abandons the sweep.
    circ_a = 16'h2B15; exp_a = 16'h2B14;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    for (n = 1; n < 11; n++) begin
      @(posedge clk); #1;
    end
    chk("midrst.dut_in_before", int'(din_a), 5);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst.busy", int'(busy_a), 0);
    chk("midrst.dut_in", int'(din_a), 0);
    chk("midrst.err", int'(err_a), 0);
    chk("midrst.ones", int'(ones_a), 0);
    chk("midrst.done", int'(done_a), 0);
    din_bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done_a || busy_a) din_bad++;
    end
    chk("midrst.stays_idle", din_bad, 0);
    run_a("after_rst", 16'h2B15, 16'h2B15, 0, 0, 7, 1, 1'b0);

    // XOR on the N_IN=2, SETTLE=3 instance: 4 cycles per vector.
    exp_b   = 4'b0110;
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    n = 1; din_bad = 0;
    while (n < 100) begin
      if (done_b) break;
      if (int'(din_b) != (n - 1) / 4) din_bad++;
      @(posedge clk); #1;
      n++;
    end
    chk("xor.latency", n, 17);
    chk("xor.din_sequence_errs", din_bad, 0);
    chk("xor.pass", int'(pass_b), 1);
    chk("xor.err", int'(err_b), 0);
    chk("xor.ones", int'(ones_b), 2);
    chk("xor.busy_at_done", int'(busy_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
